// File: rtl/key_dispatch.sv
// -----------------------------------------------------------------------------
// key_dispatch
//
// Frame-rate scheduler that shares one USB keyboard report between two
// ball-motion datapaths. Player 1 steers with W/A/S/D and player 2 with the
// arrow keys. Each tracked key is debounced over DEB_FRAMES frames. Held and
// simultaneous keys are resolved with last-pressed-wins. One direction code is
// emitted per player per frame. Both players' outputs use the arrow-code space
// (79 right, 80 left, 81 down, 82 up), so both ball instances decode the same
// way.
//
// Optional feature (macro KEY_DISPATCH_PAUSE_EN):
//   Space (HID 44) is debounced like the other keys. Each new press toggles
//   pause. While paused, both keycodes read 0, but tracking continues. When
//   the macro is undefined, code 44 is ignored and paused is tied low.
//
// Ports:
//   Reset       in   1  asynchronous, active-high reset
//   frame_clk   in   1  frame clock, all state changes on its rising edge
//   key0..key3  in   8  keyboard report slots, 0 = empty
//   keycode_p1  out  8  player 1 direction code (79/80/81/82) or 0
//   keycode_p2  out  8  player 2 direction code (79/80/81/82) or 0
//   paused      out  1  pause active (always 0 without KEY_DISPATCH_PAUSE_EN)
// -----------------------------------------------------------------------------
module key_dispatch #(
  parameter int         DEB_FRAMES = 2,   // legal range 1..7
  parameter logic [7:0] P1_UP      = 8'd26,
  parameter logic [7:0] P1_LEFT    = 8'd4,
  parameter logic [7:0] P1_DOWN    = 8'd22,
  parameter logic [7:0] P1_RIGHT   = 8'd7,
  parameter logic [7:0] P2_UP      = 8'd82,
  parameter logic [7:0] P2_LEFT    = 8'd80,
  parameter logic [7:0] P2_DOWN    = 8'd81,
  parameter logic [7:0] P2_RIGHT   = 8'd79
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] key0,
  input  logic [7:0] key1,
  input  logic [7:0] key2,
  input  logic [7:0] key3,
  output logic [7:0] keycode_p1,
  output logic [7:0] keycode_p2,
  output logic       paused
);

`ifdef KEY_DISPATCH_PAUSE_EN
  localparam int NK = 9;                  // 8 direction keys + space
`else
  localparam int NK = 8;
`endif

  localparam logic [2:0] DEB = 3'(DEB_FRAMES);

  // Arrow-code output space shared by both players.
  localparam logic [7:0] OUT_UP    = 8'd82;
  localparam logic [7:0] OUT_DOWN  = 8'd81;
  localparam logic [7:0] OUT_LEFT  = 8'd80;
  localparam logic [7:0] OUT_RIGHT = 8'd79;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_LEFT,
    S_RIGHT
  } state_t;

  // Key index layout. Within a player, the bit order is also the priority
  // order: [0] up, [1] down, [2] left, [3] right. Bits 3:0 belong to player 1
  // and bits 7:4 to player 2. Bit 8, when present, is space.
  logic [7:0]    w_code [NK];
  logic [NK-1:0] w_present;
  logic [NK-1:0] w_held;
  logic [NK-1:0] w_rise;
  logic [NK-1:0] r_held_d;
  logic [2:0]    r_cnt  [NK];

  state_t        r_state_p1, r_state_p2;
  state_t        w_next_p1,  w_next_p2;
  logic [7:0]    r_keycode_p1, r_keycode_p2;
  logic          w_paused_next;

  assign w_code[0] = P1_UP;
  assign w_code[1] = P1_DOWN;
  assign w_code[2] = P1_LEFT;
  assign w_code[3] = P1_RIGHT;
  assign w_code[4] = P2_UP;
  assign w_code[5] = P2_DOWN;
  assign w_code[6] = P2_LEFT;
  assign w_code[7] = P2_RIGHT;
`ifdef KEY_DISPATCH_PAUSE_EN
  assign w_code[8] = 8'd44;
`endif

  // A key is present if any report slot carries its code. Duplicate slots
  // collapse naturally in the OR.
  // NOTE: give every always_comb output a value before any branching, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_present = '0;
    for (int k = 0; k < NK; k++) begin
      w_present[k] = (key0 == w_code[k]) || (key1 == w_code[k]) ||
                     (key2 == w_code[k]) || (key3 == w_code[k]);
    end
  end

  // Debounce: count present frames, saturate at DEB, clear at once on absence.
  // NOTE: the counters are a small register array, not RAM, so they reset
  // with everything else. This makes a key held through reset re-debounce
  // from 0.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NK; k++) r_cnt[k] <= 3'd0;
      r_held_d <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All flops then
      // sample pre-edge values, whatever order the statements are in.
      for (int k = 0; k < NK; k++) begin
        if (!w_present[k])      r_cnt[k] <= 3'd0;
        else if (r_cnt[k] != DEB) r_cnt[k] <= r_cnt[k] + 3'd1;
      end
      r_held_d <= w_held;
    end
  end

  always_comb begin
    w_held = '0;
    for (int k = 0; k < NK; k++) w_held[k] = (r_cnt[k] == DEB);
  end

  assign w_rise = w_held & ~r_held_d;

  // Highest-priority set key (up > down > left > right), or IDLE if none.
  function automatic state_t pick(input logic [3:0] keys);
    if (keys[0])      return S_UP;
    else if (keys[1]) return S_DOWN;
    else if (keys[2]) return S_LEFT;
    else if (keys[3]) return S_RIGHT;
    else              return S_IDLE;
  endfunction

  // True while the key behind the current direction is still held.
  function automatic logic dir_held(input state_t cur, input logic [3:0] held);
    case (cur)
      S_UP:    return held[0];
      S_DOWN:  return held[1];
      S_LEFT:  return held[2];
      S_RIGHT: return held[3];
      default: return 1'b0;
    endcase
  endfunction

  // A fresh press always takes over. Losing the current key falls back to
  // whatever own key is still held. Otherwise, keep the current direction.
  function automatic state_t fsm_next(input state_t cur, input logic [3:0] held,
                                      input logic [3:0] rise);
    if (|rise)                                  return pick(rise);
    else if (cur != S_IDLE && !dir_held(cur, held)) return pick(held);
    else                                        return cur;
  endfunction

  function automatic logic [7:0] encode(input state_t s);
    case (s)
      S_UP:    return OUT_UP;
      S_DOWN:  return OUT_DOWN;
      S_LEFT:  return OUT_LEFT;
      S_RIGHT: return OUT_RIGHT;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    w_next_p1 = fsm_next(r_state_p1, w_held[3:0], w_rise[3:0]);
    w_next_p2 = fsm_next(r_state_p2, w_held[7:4], w_rise[7:4]);
  end

`ifdef KEY_DISPATCH_PAUSE_EN
  logic r_paused;

  assign w_paused_next = r_paused ^ w_rise[8];

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_paused <= 1'b0;
    else       r_paused <= w_paused_next;
  end

  assign paused = r_paused;
`else
  assign w_paused_next = 1'b0;
  assign paused        = 1'b0;
`endif

  // The outputs are registered from the next state and next pause value. A
  // direction change, or an unpause, therefore shows on the same edge that
  // causes it.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state_p1   <= S_IDLE;
      r_state_p2   <= S_IDLE;
      r_keycode_p1 <= 8'd0;
      r_keycode_p2 <= 8'd0;
    end else begin
      r_state_p1   <= w_next_p1;
      r_state_p2   <= w_next_p2;
      r_keycode_p1 <= w_paused_next ? 8'd0 : encode(w_next_p1);
      r_keycode_p2 <= w_paused_next ? 8'd0 : encode(w_next_p2);
    end
  end

  assign keycode_p1 = r_keycode_p1;
  assign keycode_p2 = r_keycode_p2;

endmodule

// File: tb/tb_key_dispatch.sv
// -----------------------------------------------------------------------------
// tb_key_dispatch
//
// Directed, self-checking bench for key_dispatch with default parameters
// (DEB_FRAMES = 2). Each step drives one frame of the keyboard report and
// queues the outputs expected after the next rising edge. Those expectations
// are popped and compared one time unit after that edge. The pause sequence is
// compiled in only when KEY_DISPATCH_PAUSE_EN is defined.
// -----------------------------------------------------------------------------
module tb_key_dispatch;

  logic       Reset;
  logic       frame_clk;
  logic [7:0] key0, key1, key2, key3;
  logic [7:0] keycode_p1, keycode_p2;
  logic       paused;

  key_dispatch dut (
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .key0       (key0),
    .key1       (key1),
    .key2       (key2),
    .key3       (key3),
    .keycode_p1 (keycode_p1),
    .keycode_p2 (keycode_p2),
    .paused     (paused)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    string      tag;
    logic [7:0] p1;
    logic [7:0] p2;
    logic       pz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  // Drive one frame and queue its expectation. Then wait for the edge, pop,
  // and compare.
  task automatic step(input string tag,
                      input logic [7:0] k0, input logic [7:0] k1,
                      input logic [7:0] k2, input logic [7:0] k3,
                      input logic [7:0] e1, input logic [7:0] e2,
                      input logic ep);
    exp_t e;
    key0 = k0; key1 = k1; key2 = k2; key3 = k3;
    e.tag = tag; e.p1 = e1; e.p2 = e2; e.pz = ep;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_p1"}, keycode_p1, e.p1);
      check({e.tag, "_p2"}, keycode_p2, e.p2);
      check({e.tag, "_pz"}, {7'd0, paused}, {7'd0, e.pz});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    key0 = 8'd0; key1 = 8'd0; key2 = 8'd0; key3 = 8'd0;
    #2;
    check("reset_p1", keycode_p1, 8'd0);
    check("reset_p2", keycode_p2, 8'd0);
    check("reset_pz", {7'd0, paused}, 8'd0);
    #1 Reset = 1'b0;

    // W held: visible after the third edge. Player 2 is unaffected.
    step("w_e1", 8'd26, 8'd0, 8'd0, 8'd0,  8'd0,  8'd0, 1'b0);
    step("w_e2", 8'd26, 8'd0, 8'd0, 8'd0,  8'd0,  8'd0, 1'b0);
    step("w_e3", 8'd26, 8'd0, 8'd0, 8'd0,  8'd82, 8'd0, 1'b0);
    step("w_e4", 8'd26, 8'd0, 8'd0, 8'd0,  8'd82, 8'd0, 1'b0);
    step("w_e5", 8'd26, 8'd0, 8'd0, 8'd0,  8'd82, 8'd0, 1'b0);
    // Add D: the latest press wins after debounce.
    step("wd_e1", 8'd26, 8'd7, 8'd0, 8'd0, 8'd82, 8'd0, 1'b0);
    step("wd_e2", 8'd26, 8'd7, 8'd0, 8'd0, 8'd82, 8'd0, 1'b0);
    step("wd_e3", 8'd26, 8'd7, 8'd0, 8'd0, 8'd79, 8'd0, 1'b0);
    // Release D: fall back to the still-held W after two edges.
    step("rd_e1", 8'd26, 8'd0, 8'd0, 8'd0, 8'd79, 8'd0, 1'b0);
    step("rd_e2", 8'd26, 8'd0, 8'd0, 8'd0, 8'd82, 8'd0, 1'b0);
    // Release all keys: idle after two edges.
    step("rw_e1", 8'd0,  8'd0, 8'd0, 8'd0, 8'd82, 8'd0, 1'b0);
    step("rw_e2", 8'd0,  8'd0, 8'd0, 8'd0, 8'd0,  8'd0, 1'b0);

    // Left and up rise in the same frame: up has priority.
    step("lu_e1", 8'd80, 8'd82, 8'd0, 8'd0, 8'd0, 8'd0,  1'b0);
    step("lu_e2", 8'd80, 8'd82, 8'd0, 8'd0, 8'd0, 8'd0,  1'b0);
    step("lu_e3", 8'd80, 8'd82, 8'd0, 8'd0, 8'd0, 8'd82, 1'b0);
    step("lu_r1", 8'd0,  8'd0,  8'd0, 8'd0, 8'd0, 8'd82, 1'b0);
    step("lu_r2", 8'd0,  8'd0,  8'd0, 8'd0, 8'd0, 8'd0,  1'b0);

    // Opposing keys: left, then right on top. Right wins, and left returns
    // once right is released.
    step("lr_e1", 8'd80, 8'd0,  8'd0, 8'd0, 8'd0, 8'd0,  1'b0);
    step("lr_e2", 8'd80, 8'd0,  8'd0, 8'd0, 8'd0, 8'd0,  1'b0);
    step("lr_e3", 8'd80, 8'd0,  8'd0, 8'd0, 8'd0, 8'd80, 1'b0);
    step("lr_e4", 8'd80, 8'd79, 8'd0, 8'd0, 8'd0, 8'd80, 1'b0);
    step("lr_e5", 8'd80, 8'd79, 8'd0, 8'd0, 8'd0, 8'd80, 1'b0);
    step("lr_e6", 8'd80, 8'd79, 8'd0, 8'd0, 8'd0, 8'd79, 1'b0);
    step("lr_e7", 8'd80, 8'd0,  8'd0, 8'd0, 8'd0, 8'd79, 1'b0);
    step("lr_e8", 8'd80, 8'd0,  8'd0, 8'd0, 8'd0, 8'd80, 1'b0);
    step("lr_e9", 8'd0,  8'd0,  8'd0, 8'd0, 8'd0, 8'd80, 1'b0);
    step("lr_e10", 8'd0, 8'd0,  8'd0, 8'd0, 8'd0, 8'd0,  1'b0);

    // S in two slots plus an untracked code. Dropping one duplicate keeps it
    // held.
    step("sd_e1", 8'd22, 8'd22, 8'd5, 8'd0, 8'd0,  8'd0, 1'b0);
    step("sd_e2", 8'd22, 8'd22, 8'd5, 8'd0, 8'd0,  8'd0, 1'b0);
    step("sd_e3", 8'd22, 8'd22, 8'd5, 8'd0, 8'd81, 8'd0, 1'b0);
    step("sd_e4", 8'd22, 8'd0,  8'd5, 8'd0, 8'd81, 8'd0, 1'b0);
    step("sd_e5", 8'd22, 8'd0,  8'd5, 8'd0, 8'd81, 8'd0, 1'b0);
    step("sd_e6", 8'd0,  8'd0,  8'd5, 8'd0, 8'd81, 8'd0, 1'b0);
    step("sd_e7", 8'd0,  8'd0,  8'd5, 8'd0, 8'd0,  8'd0, 1'b0);

    // Bouncing A never debounces.
    step("bn_e1", 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    step("bn_e2", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    step("bn_e3", 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    step("bn_e4", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    step("bn_e5", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);

    // Both players steady, then an asynchronous reset pulse mid-frame.
    step("rs_e1", 8'd7, 8'd80, 8'd0, 8'd0, 8'd0,  8'd0,  1'b0);
    step("rs_e2", 8'd7, 8'd80, 8'd0, 8'd0, 8'd0,  8'd0,  1'b0);
    step("rs_e3", 8'd7, 8'd80, 8'd0, 8'd0, 8'd79, 8'd80, 1'b0);
    step("rs_e4", 8'd7, 8'd80, 8'd0, 8'd0, 8'd79, 8'd80, 1'b0);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_p1", keycode_p1, 8'd0);
    check("async_rst_p2", keycode_p2, 8'd0);
    #2 Reset = 1'b0;
    step("rs_a1", 8'd7, 8'd80, 8'd0, 8'd0, 8'd0,  8'd0,  1'b0);
    step("rs_a2", 8'd7, 8'd80, 8'd0, 8'd0, 8'd0,  8'd0,  1'b0);
    step("rs_a3", 8'd7, 8'd80, 8'd0, 8'd0, 8'd79, 8'd80, 1'b0);
    step("rs_z1", 8'd0, 8'd0,  8'd0, 8'd0, 8'd79, 8'd80, 1'b0);
    step("rs_z2", 8'd0, 8'd0,  8'd0, 8'd0, 8'd0,  8'd0,  1'b0);

`ifdef KEY_DISPATCH_PAUSE_EN
    // Hold up for player 2, then tap space twice.
    step("pz_e1", 8'd82, 8'd0,  8'd0, 8'd0, 8'd0, 8'd0,  1'b0);
    step("pz_e2", 8'd82, 8'd0,  8'd0, 8'd0, 8'd0, 8'd0,  1'b0);
    step("pz_e3", 8'd82, 8'd0,  8'd0, 8'd0, 8'd0, 8'd82, 1'b0);
    step("pz_s1", 8'd82, 8'd44, 8'd0, 8'd0, 8'd0, 8'd82, 1'b0);
    step("pz_s2", 8'd82, 8'd44, 8'd0, 8'd0, 8'd0, 8'd82, 1'b0);
    step("pz_s3", 8'd82, 8'd44, 8'd0, 8'd0, 8'd0, 8'd0,  1'b1);
    step("pz_r1", 8'd82, 8'd0,  8'd0, 8'd0, 8'd0, 8'd0,  1'b1);
    step("pz_r2", 8'd82, 8'd0,  8'd0, 8'd0, 8'd0, 8'd0,  1'b1);
    step("pz_t1", 8'd82, 8'd44, 8'd0, 8'd0, 8'd0, 8'd0,  1'b1);
    step("pz_t2", 8'd82, 8'd44, 8'd0, 8'd0, 8'd0, 8'd0,  1'b1);
    step("pz_t3", 8'd82, 8'd44, 8'd0, 8'd0, 8'd0, 8'd82, 1'b0);
    step("pz_z1", 8'd0,  8'd0,  8'd0, 8'd0, 8'd0, 8'd82, 1'b0);
    step("pz_z2", 8'd0,  8'd0,  8'd0, 8'd0, 8'd0, 8'd0,  1'b0);
`else
    // Without the pause feature, space is just an ignored code.
    step("sp_e1", 8'd44, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    step("sp_e2", 8'd44, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    step("sp_e3", 8'd44, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    step("sp_e4", 8'd0,  8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
